// File: rtl/fetch_controller_if.sv
// rtl/fetch_controller_if.sv - fetch controller signal bundle: loader, pipeline hazard inputs, pipeline control outputs
interface fetch_controller_if #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 32
);
    logic              start;
    logic              load_start;
    logic              load_valid;
    logic [ADDR_W-1:0] load_addr;
    logic [31:0]       load_data;
    logic              load_done;
    logic              ex_mem_pcsrc;
    logic              id_stall;
    logic              id_halt;

    logic              pc_en;
    logic              pc_clr;
    logic              if_id_en;
    logic              if_id_flush;
    logic              id_ex_flush;
    logic              ex_mem_flush;
    logic              im_we;
    logic [ADDR_W-1:0] im_waddr;
    logic [31:0]       im_wdata;
    logic              load_ready;
    logic              done;
    logic [2:0]        state;
    logic [CNT_W-1:0]  fetch_count;

    modport master (
        input  start, load_start, load_valid, load_addr, load_data, load_done,
               ex_mem_pcsrc, id_stall, id_halt,
        output pc_en, pc_clr, if_id_en, if_id_flush, id_ex_flush, ex_mem_flush,
               im_we, im_waddr, im_wdata, load_ready, done, state, fetch_count
    );

    modport slave (
        output start, load_start, load_valid, load_addr, load_data, load_done,
               ex_mem_pcsrc, id_stall, id_halt,
        input  pc_en, pc_clr, if_id_en, if_id_flush, id_ex_flush, ex_mem_flush,
               im_we, im_waddr, im_wdata, load_ready, done, state, fetch_count
    );
endinterface

// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - fetch-stage sequencer: program load, run with branch/stall handling, halt drain
module fetch_controller #(
    parameter int ADDR_W       = 8,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32
) (
    input  logic           clk,
    input  logic           reset,
    fetch_controller_if.master bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        HALT  = 3'd4
    } state_t;

    localparam int            DW         = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES);

    state_t            state_q, state_d;
    logic [DW-1:0]     drain_q;
    logic              pc_clr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              im_we_q;
    logic [ADDR_W-1:0] im_waddr_q;
    logic [31:0]       im_wdata_q;
    logic              run_start;
    logic              pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_flush;
    logic              load_ready, done;

    always_comb begin
        state_d      = state_q;
        run_start    = 1'b0;
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        load_ready   = 1'b0;
        done         = 1'b0;
        case (state_q)
            IDLE, HALT: begin
                done = (state_q == HALT);
                if (bus.load_start) begin
                    state_d = LOAD;
                end else if (bus.start) begin
                    state_d   = RUN;
                    run_start = 1'b1;
                end
            end
            LOAD: begin
                load_ready = 1'b1;
                if (bus.load_done) state_d = IDLE;
            end
            RUN: begin
                if (bus.ex_mem_pcsrc) begin
                    pc_en        = 1'b1;
                    if_id_en     = 1'b1;
                    if_id_flush  = 1'b1;
                    id_ex_flush  = 1'b1;
                    ex_mem_flush = 1'b1;
                end else if (bus.id_stall) begin
                    id_ex_flush = 1'b1;
                end else begin
                    pc_en    = 1'b1;
                    if_id_en = 1'b1;
                    if (bus.id_halt) state_d = DRAIN;
                end
            end
            DRAIN: begin
                // A branch resolving now proves the halt was fetched down the wrong path.
                if (bus.ex_mem_pcsrc) begin
                    pc_en        = 1'b1;
                    if_id_en     = 1'b1;
                    if_id_flush  = 1'b1;
                    id_ex_flush  = 1'b1;
                    ex_mem_flush = 1'b1;
                    state_d      = RUN;
                end else begin
                    id_ex_flush = 1'b1;
                    if (drain_q <= DW'(1)) state_d = HALT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            drain_q    <= '0;
            pc_clr_q   <= 1'b0;
            cnt_q      <= '0;
            im_we_q    <= 1'b0;
            im_waddr_q <= '0;
            im_wdata_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_clr_q <= run_start;
            if (state_q == RUN && state_d == DRAIN) begin
                drain_q <= DRAIN_INIT;
            end else if (state_q == DRAIN) begin
                drain_q <= drain_q - 1'b1;
            end
            im_we_q <= (state_q == LOAD) && bus.load_valid;
            if (state_q == LOAD && bus.load_valid) begin
                im_waddr_q <= bus.load_addr;
                im_wdata_q <= bus.load_data;
            end
            if (run_start) begin
                cnt_q <= '0;
            end else if (pc_en && cnt_q != {CNT_W{1'b1}}) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.pc_en        = pc_en;
    assign bus.pc_clr       = pc_clr_q;
    assign bus.if_id_en     = if_id_en;
    assign bus.if_id_flush  = if_id_flush;
    assign bus.id_ex_flush  = id_ex_flush;
    assign bus.ex_mem_flush = ex_mem_flush;
    assign bus.im_we        = im_we_q;
    assign bus.im_waddr     = im_waddr_q;
    assign bus.im_wdata     = im_wdata_q;
    assign bus.load_ready   = load_ready;
    assign bus.done         = done;
    assign bus.state        = state_q;
    assign bus.fetch_count  = cnt_q;
endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - self-checking bench for fetch_controller against a behavioural model
module tb_fetch_controller;
    localparam int ADDR_W = 8;
    localparam int CNT_W  = 32;
    localparam int DRAIN  = 3;
    localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    fetch_controller_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    fetch_controller #(.ADDR_W(ADDR_W), .DRAIN_CYCLES(DRAIN), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    int          m_mode;
    int          m_drain;
    longint      m_cnt;
    bit          m_we;
    logic [7:0]  m_waddr;
    logic [31:0] m_wdata;
    bit          m_clr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_drain = 0; m_cnt = 0; m_we = 0; m_waddr = '0; m_wdata = '0; m_clr = 0;
    endtask

    function automatic void exp_comb(output bit pe, output bit ie, output bit f1, output bit f2,
                                     output bit f3, output bit rdy, output bit dn);
        pe = 0; ie = 0; f1 = 0; f2 = 0; f3 = 0; rdy = 0; dn = 0;
        if (m_mode == 1) rdy = 1;
        if (m_mode == 4) dn = 1;
        if (m_mode == 2 || m_mode == 3) begin
            if (bus.ex_mem_pcsrc) begin
                pe = 1; ie = 1; f1 = 1; f2 = 1; f3 = 1;
            end else if (m_mode == 3 || bus.id_stall) begin
                f2 = 1;
            end else begin
                pe = 1; ie = 1;
            end
        end
    endfunction

    task automatic compare_all();
        bit pe, ie, f1, f2, f3, rdy, dn;
        exp_comb(pe, ie, f1, f2, f3, rdy, dn);
        check("pc_en", 64'(bus.pc_en), 64'(pe));
        check("if_id_en", 64'(bus.if_id_en), 64'(ie));
        check("if_id_flush", 64'(bus.if_id_flush), 64'(f1));
        check("id_ex_flush", 64'(bus.id_ex_flush), 64'(f2));
        check("ex_mem_flush", 64'(bus.ex_mem_flush), 64'(f3));
        check("load_ready", 64'(bus.load_ready), 64'(rdy));
        check("done", 64'(bus.done), 64'(dn));
        check("state", 64'(bus.state), 64'(m_mode));
        check("pc_clr", 64'(bus.pc_clr), 64'(m_clr));
        check("fetch_count", 64'(bus.fetch_count), 64'(m_cnt));
        check("im_we", 64'(bus.im_we), 64'(m_we));
        if (m_we) begin
            check("im_waddr", 64'(bus.im_waddr), 64'(m_waddr));
            check("im_wdata", 64'(bus.im_wdata), 64'(m_wdata));
        end
    endtask

    task automatic model_update();
        bit pe, ie, f1, f2, f3, rdy, dn;
        bit clr = 0;
        bit we = 0;
        exp_comb(pe, ie, f1, f2, f3, rdy, dn);
        case (m_mode)
            0, 4: begin
                if (bus.load_start) m_mode = 1;
                else if (bus.start) begin m_mode = 2; clr = 1; end
            end
            1: begin
                if (bus.load_valid) begin
                    we = 1; m_waddr = bus.load_addr; m_wdata = bus.load_data;
                end
                if (bus.load_done) m_mode = 0;
            end
            2: if (!bus.ex_mem_pcsrc && !bus.id_stall && bus.id_halt) begin
                m_mode = 3; m_drain = DRAIN;
            end
            3: begin
                if (bus.ex_mem_pcsrc) m_mode = 2;
                else if (m_drain == 1) m_mode = 4;
                else m_drain--;
            end
            default: m_mode = 0;
        endcase
        if (clr) m_cnt = 0;
        else if (pe && m_cnt < CNT_MAX) m_cnt++;
        m_clr = clr;
        m_we  = we;
    endtask

    task automatic set_in(input bit ls, input bit st, input bit lv, input logic [7:0] la,
                          input logic [31:0] ld, input bit ldone, input bit pcs,
                          input bit stall, input bit halt);
        bus.load_start = ls; bus.start = st; bus.load_valid = lv; bus.load_addr = la;
        bus.load_data = ld; bus.load_done = ldone; bus.ex_mem_pcsrc = pcs;
        bus.id_stall = stall; bus.id_halt = halt;
    endtask

    task automatic drive(input bit ls, input bit st, input bit lv, input logic [7:0] la,
                         input logic [31:0] ld, input bit ldone, input bit pcs,
                         input bit stall, input bit halt);
        @(negedge clk);
        set_in(ls, st, lv, la, ld, ldone, pcs, stall, halt);
        #1;
        compare_all();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_update();
    endtask

    task automatic idle_cycle();
        drive(0, 0, 0, 8'h0, 32'h0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        model_reset();
        compare_all();
        set_in(0, 0, 0, 8'h0, 32'h0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        model_reset();
        set_in(0, 0, 0, 8'h0, 32'h0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("reset state", 64'(bus.state), 64'd0);
        check("reset fetch_count", 64'(bus.fetch_count), 64'd0);
        compare_all();
        reset = 1'b1;

        // reset in the middle of a load write
        drive(1, 0, 0, 8'h0, 32'h0, 0, 0, 0, 0); tick();
        drive(0, 0, 1, 8'h05, 32'h55, 0, 0, 0, 0); tick();
        check("mid-load im_we", 64'(bus.im_we), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("async reset im_we", 64'(bus.im_we), 64'd0);
        check("async reset state", 64'(bus.state), 64'd0);
        model_reset();
        set_in(0, 0, 0, 8'h0, 32'h0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        idle_cycle();
        check("post-reset fetch_count", 64'(bus.fetch_count), 64'd0);

        // program load of four words
        drive(1, 0, 0, 8'h0, 32'h0, 0, 0, 0, 0); tick();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1, 8'(i), 32'hA0 + 32'(i), (i == 3), 0, 0, 0);
            tick();
            check("load im_waddr", 64'(bus.im_waddr), 64'(i));
            check("load im_wdata", 64'(bus.im_wdata), 64'hA0 + 64'(i));
        end
        check("load exit state", 64'(bus.state), 64'd0);
        idle_cycle();
        check("load im_we off", 64'(bus.im_we), 64'd0);

        // start, free run, stalls
        drive(0, 1, 0, 8'h0, 32'h0, 0, 0, 0, 0); tick();
        check("start pc_clr", 64'(bus.pc_clr), 64'd1);
        check("start state", 64'(bus.state), 64'd2);
        for (int i = 0; i < 10; i++) begin
            idle_cycle();
            if (i == 0) check("pc_clr one cycle", 64'(bus.pc_clr), 64'd0);
        end
        check("free run count", 64'(bus.fetch_count), 64'd10);
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 8'h0, 32'h0, 0, 0, 1, 0);
            check("stall pc_en", 64'(bus.pc_en), 64'd0);
            check("stall if_id_en", 64'(bus.if_id_en), 64'd0);
            check("stall id_ex_flush", 64'(bus.id_ex_flush), 64'd1);
            tick();
        end
        check("stall count", 64'(bus.fetch_count), 64'd10);

        // branch overrides stall
        drive(0, 0, 0, 8'h0, 32'h0, 0, 1, 1, 0);
        check("branch pc_en", 64'(bus.pc_en), 64'd1);
        check("branch if_id_flush", 64'(bus.if_id_flush), 64'd1);
        check("branch id_ex_flush", 64'(bus.id_ex_flush), 64'd1);
        check("branch ex_mem_flush", 64'(bus.ex_mem_flush), 64'd1);
        tick();
        check("branch count", 64'(bus.fetch_count), 64'd11);

        // halt drain
        drive(0, 0, 0, 8'h0, 32'h0, 0, 0, 0, 1); tick();
        check("drain entry", 64'(bus.state), 64'd3);
        for (int i = 0; i < 2; i++) begin
            idle_cycle();
            check("drain hold", 64'(bus.state), 64'd3);
        end
        idle_cycle();
        check("halt state", 64'(bus.state), 64'd4);
        check("halt done", 64'(bus.done), 64'd1);
        check("halt pc_en", 64'(bus.pc_en), 64'd0);
        drive(0, 1, 0, 8'h0, 32'h0, 0, 0, 0, 0); tick();
        check("restart state", 64'(bus.state), 64'd2);
        check("restart pc_clr", 64'(bus.pc_clr), 64'd1);
        check("restart count", 64'(bus.fetch_count), 64'd0);

        // wrong-path halt
        drive(0, 0, 0, 8'h0, 32'h0, 0, 0, 0, 1); tick();
        idle_cycle();
        drive(0, 0, 0, 8'h0, 32'h0, 0, 1, 0, 0);
        check("wrong-path pc_en", 64'(bus.pc_en), 64'd1);
        check("wrong-path if_id_flush", 64'(bus.if_id_flush), 64'd1);
        check("wrong-path ex_mem_flush", 64'(bus.ex_mem_flush), 64'd1);
        check("wrong-path done", 64'(bus.done), 64'd0);
        tick();
        check("wrong-path state", 64'(bus.state), 64'd2);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                apply_reset();
            end else begin
                drive($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 10,
                      $urandom_range(0, 99) < 50, 8'($urandom), $urandom,
                      $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 10,
                      $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 8);
                tick();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
